instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//   Upstream neighbour of the control decoder: holds the PC and fetches one 32-bit
//   instruction per step from instruction memory over a req/ready handshake.
//   Presents the instruction plus opcode/func fields to the decoder.
//   Advances only when the decoder's pc_enable is high and no stall is requested.
//   Counts delivered instructions and flags memory timeouts.
// PARAMETERS
//   RESET_PC       32'h0000_0000  PC after reset; must be word-aligned
//   PC_STEP        4              PC increment per advance (bytes)
//   TIMEOUT_CYCLES 16             S_REQ cycles without ready before fetch_err_out sets; >=1
// PORTS
//   clk_in           in   1   clock; all logic on rising edge
//   reset_n_in       in   1   reset, synchronous, active-low
//   pc_enable_in     in   1   from decoder pc_enable_out; permits advance
//   stall_in         in   1   downstream hold; blocks advance
//   imem_req_out     out  1   fetch request to instruction memory
//   imem_addr_out    out  32  fetch address (= pc_out)
//   imem_ready_in    in   1   memory has valid imem_data_in this cycle
//   imem_data_in     in   32  instruction word from memory
//   instr_out        out  32  captured instruction
//   instr_valid_out  out  1   instr_out valid for decode
//   opcode_out       out  6   instr_out[31:26] -> decoder opcode_in
//   func_out         out  6   instr_out[5:0]   -> decoder func_in
//   pc_out           out  32  PC of current fetch/instruction
//   fetch_count_out  out  16  instructions delivered, wraps 16'hFFFF->0
//   fetch_err_out    out  1   sticky timeout flag
// BEHAVIOUR
//   Reset (reset_n_in=0 at edge, overrides all): state<=S_IDLE, pc<=RESET_PC,
//     instr_out<=0 (NOP), instr_valid_out<=0, fetch_count_out<=0, fetch_err_out<=0,
//     wait counter<=0. imem_req_out=0 while in S_IDLE.
//   Reset mid-transfer: any outstanding request is abandoned; no capture.
//   FSM:
//     S_IDLE: one cycle after reset release -> S_REQ.
//     S_REQ:  imem_req_out=1, imem_addr_out=pc, address held stable until ready.
//             imem_ready_in=1: instr_out<=imem_data_in, instr_valid_out<=1,
//             fetch_count_out+=1, wait counter<=0 -> S_HOLD.
//             else wait counter+=1; when it reaches TIMEOUT_CYCLES: fetch_err_out<=1,
//             counter<=0, stay in S_REQ, request unchanged.
//     S_HOLD: imem_req_out=0, instr_valid_out=1, instr_out/pc_out held.
//             pc_enable_in=1 && stall_in=0: pc<=pc+PC_STEP (mod 2^32, 0xFFFFFFFC->0),
//             instr_valid_out<=0 -> S_REQ. Otherwise stay.
//   Zero-wait throughput: one instruction per 2 cycles (REQ, HOLD).
//   Latency: ready at edge N -> instr_valid_out=1 from cycle N+1.
//   opcode_out/func_out are combinational slices of instr_out.
//   fetch_err_out clears only on reset; a later ready still completes the fetch.
//   stall_in has priority over pc_enable_in; ignored outside S_HOLD.
// CONFIGURATION
//   FETCH_REDIRECT_EN defined: adds redirect_in (in,1) and redirect_pc_in (in,32).
//     redirect_in=1 in S_REQ or S_HOLD: pc<=redirect_pc_in, instr_valid_out<=0,
//     wait counter<=0 -> S_REQ. Ignores stall_in, overrides pc_enable_in, and beats
//     simultaneous imem_ready_in (data discarded, fetch_count_out not incremented).
//     Ignored in S_IDLE and during reset.
//   FETCH_REDIRECT_EN undefined: ports absent; PC is strictly sequential.
// TESTING
//   1 Reset, ready=1 always, pc_enable=1 -> addr 0x0,0x4,0x8; valid every 2nd cycle;
//     instr 0x00851020 gives opcode 0x00, func 0x20; count 1,2,3.
//   2 Ready asserted 3 cycles after req -> addr stable 4 cycles, valid next cycle,
//     count +1 only.
//   3 stall_in=1 for 5 cycles in S_HOLD with pc_enable=1 -> instr_out/pc_out
//     unchanged, req=0; advances the cycle after stall drops.
//   4 TIMEOUT_CYCLES=8, ready held 0 -> fetch_err_out=1 after 8 S_REQ cycles,
//     req stays 1; ready later -> capture, err stays 1.
//   5 reset_n_in=0 mid-S_REQ -> next cycle req=0, valid=0, pc=RESET_PC, err=0,
//     count=0; RESET_PC=32'hFFFFFFFC -> second fetch addr 0x0.
//   6 FETCH_REDIRECT_EN: redirect to 0x40 in S_HOLD -> next req addr 0x40;
//     redirect coincident with ready -> data dropped, count unchanged.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: holds the PC and fetches one 32-bit instruction per step over a
// req/ready handshake with instruction memory. The fetched word is held for the
// decoder until it allows the PC to advance. Delivered instructions are counted,
// and a sticky flag records any request that waited TIMEOUT_CYCLES without ready.
// Optional feature macro: FETCH_REDIRECT_EN (adds redirect_in / redirect_pc_in).
module instr_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned PC_STEP        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_in,
  input  logic        reset_n_in,
  input  logic        pc_enable_in,
  input  logic        stall_in,
`ifdef FETCH_REDIRECT_EN
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
`endif
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ready_in,
  input  logic [31:0] imem_data_in,
  output logic [31:0] instr_out,
  output logic        instr_valid_out,
  output logic [5:0]  opcode_out,
  output logic [5:0]  func_out,
  output logic [31:0] pc_out,
  output logic [15:0] fetch_count_out,
  output logic        fetch_err_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [31:0] STEP      = 32'(PC_STEP);
  localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_valid;
  logic [15:0] r_count;
  logic        r_err;
  logic [31:0] r_wait;

  logic        w_advance;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;

  assign w_advance = pc_enable_in && !stall_in;

`ifdef FETCH_REDIRECT_EN
  assign w_redirect    = redirect_in && (r_state != S_IDLE);
  assign w_redirect_pc = redirect_pc_in;
`else
  assign w_redirect    = 1'b0;
  assign w_redirect_pc = '0;
`endif

  // Fetch FSM, PC, captured instruction, delivery counter and timeout tracking
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
      r_err   <= 1'b0;
      r_wait  <= '0;
    end else if (w_redirect) begin
      // Redirect wins over ready, stall and pc_enable; any returning data is dropped
      r_state <= S_REQ;
      r_pc    <= w_redirect_pc;
      r_valid <= 1'b0;
      r_wait  <= '0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (imem_ready_in) begin
            r_instr <= imem_data_in;
            r_valid <= 1'b1;
            r_count <= r_count + 16'd1;
            r_wait  <= '0;
            r_state <= S_HOLD;
          end else if (r_wait == WAIT_LAST) begin
            r_err  <= 1'b1;
            r_wait <= '0;
          end else begin
            r_wait <= r_wait + 32'd1;
          end
        end
        S_HOLD: begin
          if (w_advance) begin
            r_pc    <= r_pc + STEP;
            r_valid <= 1'b0;
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

  // Request and field outputs derived from registered state
  always_comb begin
    imem_req_out    = (r_state == S_REQ);
    imem_addr_out   = r_pc;
    pc_out          = r_pc;
    instr_out       = r_instr;
    instr_valid_out = r_valid;
    opcode_out      = r_instr[31:26];
    func_out        = r_instr[5:0];
    fetch_count_out = r_count;
    fetch_err_out   = r_err;
  end

endmodule
